adder: RTL and testbench

Registered 32-bit two-operand adder for the multicycle MIPS datapath, used mainly for PC increment (PC + 4) and branch-target computation (PC + offset). It samples both operands on every rising clock edge and presents their modulo-2^32 sum one cycle later, with carry and signed-overflow flags. The core is a 32-bit carry-lookahead adder built from eight 4-bit lookahead groups and a second-level group carry unit, followed by an output register stage.

---
 rtl/adder.sv | 91 +++++++++
 tb/tb_adder.sv | 124 ++++++++++++
 2 files changed

// File: rtl/adder.sv
// Registered 32-bit adder for the multicycle MIPS datapath (PC increment, branch targets).
// Two-level carry-lookahead core with one output register stage; the sum appears one cycle after the operands.
module adder (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] input1,
    input  logic [31:0] input2,
    output logic [31:0] result,
    output logic        carry_out,
    output logic        overflow
);

    logic [31:0] gen_bit;
    logic [31:0] prop_bit;
    logic [31:0] bit_c;
    logic [7:0]  grp_g;
    logic [7:0]  grp_p;
    logic [8:0]  grp_c;

    logic [31:0] result_d, result_q;
    logic        carry_d, carry_q;
    logic        overflow_d, overflow_q;

    assign gen_bit  = input1 & input2;
    assign prop_bit = input1 ^ input2;

    // First level: each 4-bit group yields group G/P and its internal bit carries.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_group
            logic [3:0] g;
            logic [3:0] p;
            logic       cin;

            assign g   = gen_bit[gi*4 +: 4];
            assign p   = prop_bit[gi*4 +: 4];
            assign cin = grp_c[gi];

            assign grp_g[gi] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                             | (p[3] & p[2] & p[1] & g[0]);
            assign grp_p[gi] = &p;

            assign bit_c[gi*4 + 0] = cin;
            assign bit_c[gi*4 + 1] = g[0] | (p[0] & cin);
            assign bit_c[gi*4 + 2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
            assign bit_c[gi*4 + 3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                                   | (p[2] & p[1] & p[0] & cin);
        end
    endgenerate

    // Second level: each group carry is a flat sum of products over lower groups (carry-in is 0).
    always_comb begin
        logic acc;
        logic term;
        grp_c    = '0;
        for (int i = 1; i <= 8; i++) begin
            acc = 1'b0;
            for (int j = 0; j < i; j++) begin
                term = grp_g[j];
                for (int k = j + 1; k < i; k++) begin
                    term = term & grp_p[k];
                end
                acc = acc | term;
            end
            grp_c[i] = acc;
        end
    end

    always_comb begin
        result_d   = prop_bit ^ bit_c;
        carry_d    = grp_c[8];
        overflow_d = (input1[31] == input2[31]) && (result_d[31] != input1[31]);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            result_q   <= '0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            result_q   <= result_d;
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
        end
    end

    assign result    = result_q;
    assign carry_out = carry_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_adder.sv
// Scoreboard bench for adder: stimulus pushes expected results per edge, a monitor pops and checks after each edge.
module tb_adder;

    logic        clock;
    logic        reset_n;
    logic [31:0] input1;
    logic [31:0] input2;
    logic [31:0] result;
    logic        carry_out;
    logic        overflow;

    typedef struct {
        logic [31:0] r;
        logic        c;
        logic        v;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    logic [31:0] last_r;
    logic        last_c;
    logic        last_v;
    logic        last_valid = 1'b0;

    adder dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .input1    (input1),
        .input2    (input2),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    initial clock = 1'b0;
    always #50 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Drive one edge's worth of stimulus at the falling edge and record what the next rising edge must produce.
    task automatic apply(input string name, input logic rst_n, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic ec, input logic ev);
        exp_t e;
        @(negedge clock);
        reset_n = rst_n;
        input1  = a;
        input2  = b;
        #1;
        if (last_valid) begin
            check({name, "/hold_r"}, result, last_r);
            check({name, "/hold_c"}, {31'b0, carry_out}, {31'b0, last_c});
            check({name, "/hold_v"}, {31'b0, overflow}, {31'b0, last_v});
        end
        e.r = er; e.c = ec; e.v = ev; e.name = name;
        exp_q.push_back(e);
        last_r = er; last_c = ec; last_v = ev; last_valid = 1'b1;
    endtask

    // Monitor: the register presents a new value after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({e.name, "/result"}, result, e.r);
                check({e.name, "/carry"}, {31'b0, carry_out}, {31'b0, e.c});
                check({e.name, "/ovf"}, {31'b0, overflow}, {31'b0, e.v});
                $display("txn %s: result=0x%08h c=%0b v=%0b", e.name, result, carry_out, overflow);
            end
        end
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [32:0] s;
        logic        v;

        reset_n = 1'b0;
        input1  = 32'h12345678;
        input2  = 32'h1;

        apply("reset0", 1'b0, 32'h12345678, 32'h1, 32'h0, 1'b0, 1'b0);
        apply("reset1", 1'b0, 32'h12345678, 32'h1, 32'h0, 1'b0, 1'b0);
        apply("pc_inc", 1'b1, 32'h00400000, 32'h4, 32'h00400004, 1'b0, 1'b0);
        apply("uwrap",  1'b1, 32'hFFFFFFFF, 32'h1, 32'h00000000, 1'b1, 1'b0);
        apply("sovf_p", 1'b1, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0, 1'b1);
        apply("sovf_n", 1'b1, 32'h80000000, 32'h80000000, 32'h0, 1'b1, 1'b1);
        apply("br_back", 1'b1, 32'h00400010, 32'hFFFFFFF0, 32'h00400000, 1'b1, 1'b0);
        apply("full_c", 1'b1, 32'h0F0F0F0F, 32'hF0F0F0F1, 32'h0, 1'b1, 1'b0);
        apply("mixed",  1'b1, 32'h89ABCDEF, 32'h12345678, 32'h9BE02467, 1'b0, 1'b0);
        apply("rst_win", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0);
        apply("resume", 1'b1, 32'h00000003, 32'h00000005, 32'h00000008, 1'b0, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            b = $urandom;
            if (i == 500) begin
                apply("rnd_rst", 1'b0, a, b, 32'h0, 1'b0, 1'b0);
            end else begin
                s = {1'b0, a} + {1'b0, b};
                v = (a[31] == b[31]) && (s[31] != a[31]);
                apply($sformatf("rnd%0d", i), 1'b1, a, b, s[31:0], s[32], v);
            end
        end

        repeat (2) @(negedge clock);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
